// File: rtl/spm_pkg.sv
// Shared definitions for the RISC_SPM program loader.
package spm_pkg;

  localparam int SPM_WORD_W = 8;
  localparam int SPM_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_HDR_ADDR,
    ST_HDR_LEN,
    ST_DATA,
    ST_RUN_WAIT,
    ST_RUN
  } ld_state_e;

endpackage

// File: rtl/spm_ld_delay.sv
// Down-counter timing the gap between end-of-load and CPU release.
module spm_ld_delay #(
  parameter int DELAY = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(DELAY - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/spm_prog_loader.sv
// Boot loader: optional memory clear, record-stream load, then CPU release.
module spm_prog_loader
  import spm_pkg::*;
#(
  parameter int WORD_W        = SPM_WORD_W,
  parameter int ADDR_W        = SPM_ADDR_W,
  parameter int CLEAR_ON_BOOT = 1,
  parameter int RUN_DELAY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done
);

  // MSB set means the clear sweep is finished (or skipped)
  localparam logic [ADDR_W:0] CLR_SKIP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CLR_INIT =
    (CLEAR_ON_BOOT != 0) ? '0 : CLR_SKIP;

  ld_state_e         r_state, w_state;
  logic [ADDR_W:0]   r_clr, w_clr;
  logic [ADDR_W-1:0] r_ptr, w_ptr;
  logic [WORD_W-1:0] r_cnt, w_cnt;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [WORD_W-1:0] r_wdata, w_wdata;
  logic              w_acc;
  logic              w_dly_load;
  logic              w_dly_en;
  logic              w_expire;

  assign in_ready = r_state inside {ST_HDR_ADDR, ST_HDR_LEN, ST_DATA};
  assign w_acc    = in_valid && in_ready;
  assign w_dly_en = (r_state == ST_RUN_WAIT);

  always_comb begin
    w_state    = r_state;
    w_clr      = r_clr;
    w_ptr      = r_ptr;
    w_cnt      = r_cnt;
    w_we       = 1'b0;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_dly_load = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        if (r_clr[ADDR_W]) begin
          w_state = ST_HDR_ADDR;
        end else begin
          w_we    = 1'b1;
          w_addr  = r_clr[ADDR_W-1:0];
          w_wdata = '0;
          w_clr   = r_clr + 1'b1;
        end
      end
      ST_HDR_ADDR: begin
        if (w_acc) begin
          w_ptr   = in_data[ADDR_W-1:0];
          w_state = ST_HDR_LEN;
        end
      end
      ST_HDR_LEN: begin
        if (w_acc) begin
          w_cnt = in_data;
          if (in_data == '0) begin
            w_state    = ST_RUN_WAIT;
            w_dly_load = 1'b1;
          end else begin
            w_state = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_acc) begin
          w_we    = 1'b1;
          w_addr  = r_ptr;
          w_wdata = in_data;
          w_ptr   = r_ptr + 1'b1;
          w_cnt   = r_cnt - 1'b1;
          if (r_cnt == WORD_W'(1)) begin
            w_state = ST_HDR_ADDR;
          end
        end
      end
      ST_RUN_WAIT: begin
        if (w_expire) begin
          w_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (reload) begin
          w_clr = '0;
          if (CLEAR_ON_BOOT != 0) begin
            w_state = ST_CLEAR;
          end else begin
            w_state = ST_HDR_ADDR;
          end
        end
      end
      default: begin
        w_state = ST_CLEAR;
        w_clr   = CLR_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_clr   <= CLR_INIT;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state;
      r_clr   <= w_clr;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  spm_ld_delay #(
    .DELAY(RUN_DELAY)
  ) u_delay (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_dly_load),
    .i_en    (w_dly_en),
    .o_expire(w_expire)
  );

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rst   = !((r_state == ST_RUN) || w_expire);
  assign busy      = (r_state != ST_RUN);
  assign done      = w_expire;

endmodule

// File: tb/tb_spm_prog_loader.sv
// Scoreboard bench for spm_prog_loader (clearing and non-clearing builds).
module tb_spm_prog_loader;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, reload, in_valid;
  logic [7:0] in_data;
  logic       rdy_a, we_a, crst_a, busy_a, done_a;
  logic       rdy_b, we_b, crst_b, busy_b, done_b;
  logic [7:0] addr_a, wd_a, addr_b, wd_b;
  logic       sel;

  logic       w_rdy, w_we, w_crst, w_busy, w_done;
  logic [7:0] w_addr, w_wdata;

  int         checks = 0;
  int         errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic [7:0] mem[256];
  logic [7:0] exp_mem[256];

  always #5 clk = ~clk;

  spm_prog_loader #(
    .WORD_W(8), .ADDR_W(8), .CLEAR_ON_BOOT(1), .RUN_DELAY(D)
  ) u_a (
    .clk(clk), .rst(rst_a), .reload(reload),
    .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .cpu_rst(crst_a), .busy(busy_a), .done(done_a)
  );

  spm_prog_loader #(
    .WORD_W(8), .ADDR_W(8), .CLEAR_ON_BOOT(0), .RUN_DELAY(D)
  ) u_b (
    .clk(clk), .rst(rst_b), .reload(reload),
    .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .cpu_rst(crst_b), .busy(busy_b), .done(done_b)
  );

  assign w_rdy   = sel ? rdy_b  : rdy_a;
  assign w_we    = sel ? we_b   : we_a;
  assign w_addr  = sel ? addr_b : addr_a;
  assign w_wdata = sel ? wd_b   : wd_a;
  assign w_crst  = sel ? crst_b : crst_a;
  assign w_busy  = sel ? busy_b : busy_a;
  assign w_done  = sel ? done_b : done_a;

  // Every write must match the oldest outstanding expectation
  always @(posedge clk) begin
    #1;
    if (w_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d data=%02h, required no write",
                 w_addr, w_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({w_addr, w_wdata} !== mon_e) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   w_addr, w_wdata, mon_e[15:8], mon_e[7:0]);
        end
      end
      mem[w_addr] = w_wdata;
    end
  end

  task automatic prep_clear();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({8'(i), 8'h00});
      exp_mem[i] = 8'h00;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (w_rdy !== 1'b1 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        errors++;
        $display("FAIL mem_%s[%0d]: got %02h, required %02h",
                 tag, i, mem[i], exp_mem[i]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_%s: got %0d writes missing, required 0",
               tag, exp_q.size());
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit rl,
                           input bit gaps, input bit push,
                           input logic [7:0] a);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = w;
    reload   = rl;
    n = 0;
    while (w_rdy !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (w_rdy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=%b, required 1", w_rdy);
      in_valid = 1'b0;
      reload   = 1'b0;
      return;
    end
    if (push) exp_q.push_back({a, w});
    @(posedge clk); #1;
    in_valid = 1'b0;
    reload   = 1'b0;
  endtask

  task automatic check_release();
    for (int k = 1; k <= D; k++) begin
      checks++;
      if (k < D) begin
        if ({w_crst, w_done} !== 2'b10) begin
          errors++;
          $display("FAIL run_wait_%0d: got cpu_rst=%b done=%b, required 1 0",
                   k, w_crst, w_done);
        end
        @(posedge clk); #1;
      end else if ({w_crst, w_done} !== 2'b01) begin
        errors++;
        $display("FAIL release: got cpu_rst=%b done=%b, required 0 1",
                 w_crst, w_done);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({w_crst, w_done, w_busy, w_rdy} !== 4'b0000) begin
      errors++;
      $display("FAIL run_state: got cpu_rst=%b done=%b busy=%b rdy=%b, required 0 0 0 0",
               w_crst, w_done, w_busy, w_rdy);
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gaps,
                             input bit rl_data);
    int         ph = 0;
    logic [7:0] ptr = '0;
    logic [7:0] rem = '0;
    bit         first = 1'b1;
    foreach (s[i]) begin
      case (ph)
        0: begin
          send_word(s[i], 1'b0, gaps, 1'b0, 8'h00);
          ptr = s[i];
          ph  = 1;
        end
        1: begin
          send_word(s[i], 1'b0, gaps, 1'b0, 8'h00);
          rem = s[i];
          if (rem == 0) begin
            check_release();
            ph = 3;
          end else begin
            ph = 2;
          end
        end
        2: begin
          send_word(s[i], rl_data && first, gaps, 1'b1, ptr);
          exp_mem[ptr] = s[i];
          ptr++;
          rem--;
          if (rl_data && first) begin
            checks++;
            if ({w_rdy, w_busy, w_crst} !== 3'b111) begin
              errors++;
              $display("FAIL reload_in_data: got rdy=%b busy=%b cpu_rst=%b, required 1 1 1",
                       w_rdy, w_busy, w_crst);
            end
          end
          first = 1'b0;
          if (rem == 0) ph = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic pulse_reload();
    int n;
    if (!sel) prep_clear();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    checks++;
    if ({w_crst, w_busy, w_rdy} !== {1'b1, 1'b1, sel}) begin
      errors++;
      $display("FAIL reload_resp: got cpu_rst=%b busy=%b rdy=%b, required 1 1 %b",
               w_crst, w_busy, w_rdy, sel);
    end
    wait_ready(n);
    if (!sel) begin
      checks++;
      if (n != 257) begin
        errors++;
        $display("FAIL reload_clear_len: got %0d cycles, required 257", n);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({w_rdy, w_we, w_addr, w_wdata, w_crst, w_busy, w_done} !==
        {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s: got rdy=%b we=%b addr=%02h wd=%02h crst=%b busy=%b done=%b, required 0 0 00 00 1 1 0",
               tag, w_rdy, w_we, w_addr, w_wdata, w_crst, w_busy, w_done);
    end
  endtask

  task automatic release_and_clear(input string tag);
    int n;
    bit crst_ok = 1'b1;
    prep_clear();
    rst_a = 1'b0;
    n = 0;
    while (n < 600) begin
      @(posedge clk); #1;
      n++;
      if (w_crst !== 1'b1) crst_ok = 1'b0;
      if (w_rdy === 1'b1) break;
    end
    checks++;
    if (n != 257) begin
      errors++;
      $display("FAIL %s_ready_cycle: got %0d, required 257", tag, n);
    end
    checks++;
    if (!crst_ok) begin
      errors++;
      $display("FAIL %s_cpu_rst: got a low cpu_rst, required 1", tag);
    end
    check_mem(tag);
  endtask

  task automatic test_reset();
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    reload = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    foreach (mem[i]) mem[i] = 8'hFF;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_reset_vals("reset_vals");
    release_and_clear("clear");
  endtask

  task automatic build_image(output logic [7:0] img[$]);
    img = '{8'h00, 8'd15,
            8'h00, 8'h52, 8'd130, 8'h53, 8'd131, 8'h51, 8'd128, 8'h50,
            8'd129, 8'h21, 8'h80, 8'd134, 8'h1B, 8'h73, 8'd140,
            8'd128, 8'd4, 8'd6, 8'd1, 8'd2, 8'd0,
            8'h00, 8'h00};
  endtask

  task automatic test_program();
    logic [7:0] img[$];
    build_image(img);
    send_stream(img, 1'b0, 1'b0);
    check_mem("program");
  endtask

  task automatic test_gaps();
    logic [7:0] img[$];
    build_image(img);
    pulse_reload();
    send_stream(img, 1'b1, 1'b0);
    check_mem("gaps");
  endtask

  task automatic test_wrap();
    logic [7:0] s[$];
    logic [7:0] want[3];
    logic [7:0] at[3];
    s = '{8'd255, 8'd3, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00};
    want = '{8'hA1, 8'hA2, 8'hA3};
    at = '{8'd255, 8'd0, 8'd1};
    pulse_reload();
    send_stream(s, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[at[i]] !== want[i]) begin
        errors++;
        $display("FAIL wrap[%0d]: got %02h, required %02h",
                 at[i], mem[at[i]], want[i]);
      end
    end
    check_mem("wrap");
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[$];
    pulse_reload();
    send_word(8'd16, 1'b0, 1'b0, 1'b0, 8'h00);
    send_word(8'd4, 1'b0, 1'b0, 1'b0, 8'h00);
    send_word(8'h11, 1'b0, 1'b0, 1'b1, 8'd16);
    send_word(8'h22, 1'b0, 1'b0, 1'b1, 8'd17);
    rst_a    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(posedge clk); #1;
    check_reset_vals("midrst_vals");
    @(posedge clk); #1;
    checks++;
    if (w_we !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_write: got we=%b, required 0", w_we);
    end
    in_valid = 1'b0;
    release_and_clear("midrst_clear");
    s = '{8'h20, 8'd2, 8'h5A, 8'h5B, 8'h00, 8'h00};
    send_stream(s, 1'b0, 1'b0);
    check_mem("midrst_reload");
  endtask

  task automatic test_reload();
    logic [7:0] s[$];
    int n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    sel   = 1'b1;
    rst_b = 1'b0;
    wait_ready(n);
    checks++;
    if (w_rdy !== 1'b1) begin
      errors++;
      $display("FAIL noclr_ready: got %b after %0d cycles, required 1", w_rdy, n);
    end
    s = '{8'h40, 8'd3, 8'h01, 8'h02, 8'h03, 8'h90, 8'd1, 8'h77,
          8'h00, 8'h00};
    send_stream(s, 1'b0, 1'b1);
    check_mem("image1");
    pulse_reload();
    s = '{8'h41, 8'd2, 8'hC1, 8'hC2, 8'h00, 8'h00};
    send_stream(s, 1'b0, 1'b0);
    check_mem("image2");
  endtask

  initial begin
    test_reset();
    test_program();
    test_gaps();
    test_wrap();
    test_reset_mid();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
